// File: rtl/dfr_sample_sequencer.sv
// Sequences sample indices through init/train/test phases towards a reservoir consumer.
// Latency: first sample_valid one cycle after an accepted start; one transfer per cycle when ready.
// Backpressure: sample_ready=0 freezes all sample outputs; nothing advances until a transfer.
module dfr_sample_sequencer #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [31:0]           num_init_samples,
  input  logic [31:0]           num_train_samples,
  input  logic [31:0]           num_test_samples,
  input  logic                  sample_ready,
  output logic                  sample_valid,
  output logic [ADDR_WIDTH-1:0] sample_addr,
  output logic [1:0]            sample_phase,
  output logic                  sample_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_TRAIN = 3'd2,
    S_TEST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state_q, state_d;
  logic [31:0]             phase_cnt_q, phase_cnt_d;
  logic [31:0]             cnt_init_q, cnt_init_d;
  logic [31:0]             cnt_train_q, cnt_train_d;
  logic [31:0]             cnt_test_q, cnt_test_d;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic                    run_d;
  logic [1:0]              phase_d;
  logic                    last_d;
  logic                    transfer;

  // First phase at or after index 'from' whose count is nonzero; DONE when none is left.
  function automatic state_t pick_phase(input logic [1:0] from, input logic [31:0] c0,
                                        input logic [31:0] c1, input logic [31:0] c2);
    state_t r;
    r = S_DONE;
    if (from == 2'd0 && c0 != 32'd0)
      r = S_INIT;
    else if (from <= 2'd1 && c1 != 32'd0)
      r = S_TRAIN;
    else if (from <= 2'd2 && c2 != 32'd0)
      r = S_TEST;
    return r;
  endfunction

  // Phase code presented on sample_phase; zero outside a run.
  function automatic logic [1:0] phase_of(input state_t s);
    logic [1:0] p;
    p = 2'd0;
    case (s)
      S_TRAIN: p = 2'd1;
      S_TEST:  p = 2'd2;
      default: p = 2'd0;
    endcase
    return p;
  endfunction

  // Latched sample count belonging to a run state.
  function automatic logic [31:0] count_of(input state_t s, input logic [31:0] c0,
                                           input logic [31:0] c1, input logic [31:0] c2);
    logic [31:0] c;
    c = 32'd0;
    case (s)
      S_INIT:  c = c0;
      S_TRAIN: c = c1;
      S_TEST:  c = c2;
      default: c = 32'd0;
    endcase
    return c;
  endfunction

  assign transfer = sample_valid & sample_ready;

  // Next-state and next-output computation; outputs are precomputed here so they can be registered.
  always_comb begin
    state_d     = state_q;
    phase_cnt_d = phase_cnt_q;
    cnt_init_d  = cnt_init_q;
    cnt_train_d = cnt_train_q;
    cnt_test_d  = cnt_test_q;
    addr_d      = sample_addr;

    if (abort) begin
      state_d     = S_IDLE;
      phase_cnt_d = 32'd0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            cnt_init_d  = num_init_samples;
            cnt_train_d = num_train_samples;
            cnt_test_d  = num_test_samples;
            addr_d      = '0;
            phase_cnt_d = 32'd0;
            state_d     = pick_phase(2'd0, num_init_samples, num_train_samples, num_test_samples);
          end
        end
        S_INIT, S_TRAIN, S_TEST: begin
          if (transfer) begin
            addr_d = sample_addr + ADDR_ONE;
            if (sample_last) begin
              phase_cnt_d = 32'd0;
              state_d     = pick_phase(phase_of(state_q) + 2'd1, cnt_init_q, cnt_train_q, cnt_test_q);
            end else begin
              phase_cnt_d = phase_cnt_q + 32'd1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    run_d   = (state_d == S_INIT) || (state_d == S_TRAIN) || (state_d == S_TEST);
    phase_d = phase_of(state_d);
    last_d  = run_d &&
              (phase_cnt_d == count_of(state_d, cnt_init_d, cnt_train_d, cnt_test_d) - 32'd1);
  end

  // State, counters and all outputs registered together; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      phase_cnt_q  <= 32'd0;
      cnt_init_q   <= 32'd0;
      cnt_train_q  <= 32'd0;
      cnt_test_q   <= 32'd0;
      sample_valid <= 1'b0;
      sample_addr  <= '0;
      sample_phase <= 2'd0;
      sample_last  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_cnt_q  <= phase_cnt_d;
      cnt_init_q   <= cnt_init_d;
      cnt_train_q  <= cnt_train_d;
      cnt_test_q   <= cnt_test_d;
      sample_valid <= run_d;
      sample_addr  <= addr_d;
      sample_phase <= phase_d;
      sample_last  <= last_d;
      busy         <= run_d;
      done         <= (state_d == S_DONE);
    end
  end

endmodule

// File: tb/tb_dfr_sample_sequencer.sv
// Bench for dfr_sample_sequencer: two instances (16-bit and 4-bit address) share stimulus.
// Expected samples come from a per-run list built from the phase counts.
// Ready is driven always-on, in a 1,0,0,1 pattern, or randomly.
module tb_dfr_sample_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, abort, sample_ready;
  logic [31:0] n0, n1, n2;
  logic        v16, l16, b16, d16;
  logic [15:0] a16;
  logic [1:0]  p16;
  logic        v4, l4, b4, d4;
  logic [3:0]  a4;
  logic [1:0]  p4;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int addr;
    int phase;
    bit last;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  dfr_sample_sequencer #(.ADDR_WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .num_init_samples(n0), .num_train_samples(n1), .num_test_samples(n2),
    .sample_ready(sample_ready), .sample_valid(v16), .sample_addr(a16),
    .sample_phase(p16), .sample_last(l16), .busy(b16), .done(d16)
  );

  dfr_sample_sequencer #(.ADDR_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .num_init_samples(n0), .num_train_samples(n1), .num_test_samples(n2),
    .sample_ready(sample_ready), .sample_valid(v4), .sample_addr(a4),
    .sample_phase(p4), .sample_last(l4), .busy(b4), .done(d4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Pulse start with the given counts and build the list of samples the run must produce.
  task automatic start_run(input int c0, input int c1, input int c2);
    int k;
    int cnt;
    k = 0;
    q.delete();
    n0 = c0; n1 = c1; n2 = c2;
    start = 1'b1;
    for (int p = 0; p < 3; p++) begin
      cnt = (p == 0) ? c0 : (p == 1) ? c1 : c2;
      for (int i = 0; i < cnt; i++) begin
        q.push_back('{k, p, (i == cnt - 1)});
        k++;
      end
    end
    @(negedge clk);
    start = 1'b0;
    n0 = $urandom; n1 = $urandom; n2 = $urandom;
    chk("valid_after_start", v16, q.size() != 0);
    chk("busy_after_start", b16, q.size() != 0);
    chk("done_after_start", d16, q.size() == 0);
  endtask

  // Consume the run, comparing each presented sample to the expected list until done.
  task automatic run(input int mode, input int limit);
    bit fin;
    bit prev_stall;
    logic [15:0] prev_addr;
    int cyc;
    fin = 1'b0; prev_stall = 1'b0; prev_addr = '0; cyc = 0;
    while (!fin && cyc < limit) begin
      case (mode)
        0:       sample_ready = 1'b1;
        1:       sample_ready = 1'($urandom_range(0, 1));
        default: sample_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      endcase
      start = (mode == 1) && v16 && ($urandom_range(0, 3) == 0);
      if (prev_stall) begin
        chk("stall_hold_valid", v16, 1);
        chk("stall_hold_addr", a16, prev_addr);
      end
      if (v16) begin
        if (q.size() == 0) begin
          chk("extra_sample", v16, 0);
        end else begin
          chk("addr16", a16, q[0].addr % 65536);
          chk("addr4", a4, q[0].addr % 16);
          chk("phase", p16, q[0].phase);
          chk("last", l16, q[0].last);
          chk("last4", l4, q[0].last);
          chk("valid4", v4, 1);
          chk("busy_in_run", b16, 1);
          chk("done_in_run", d16, 0);
          prev_stall = !sample_ready;
          prev_addr  = a16;
          if (sample_ready) q.delete(0);
        end
      end else begin
        prev_stall = 1'b0;
        chk("done_at_end", d16, 1);
        chk("done4_at_end", d4, 1);
        chk("queue_empty_at_end", q.size(), 0);
        chk("busy_at_end", b16, 0);
        fin = 1'b1;
      end
      if (!fin) begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    sample_ready = 1'b0;
    if (!fin) chk("run_timeout_done", d16, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; sample_ready = 1'b0;
    n0 = 32'd0; n1 = 32'd0; n2 = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_valid", v16, 0);
    chk("rst_addr", a16, 0);
    chk("rst_phase", p16, 0);
    chk("rst_last", l16, 0);
    chk("rst_busy", b16, 0);
    chk("rst_done", d16, 0);
    chk("rst_valid4", v4, 0);
    rst = 1'b0;

    // abort beats a simultaneous start
    abort = 1'b1; start = 1'b1; n0 = 32'd3;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    chk("abort_over_start_valid", v16, 0);
    chk("abort_over_start_busy", b16, 0);
    chk("abort_over_start_done", d16, 0);

    start_run(2, 3, 1); run(0, 50);
    repeat (3) @(negedge clk);
    chk("done_sticky", d16, 1);
    chk("done_sticky_valid", v16, 0);

    start_run(0, 2, 0); run(0, 50);
    start_run(0, 0, 0); run(0, 10);
    start_run(4, 0, 0); run(2, 50);
    start_run(0, 20, 0); run(0, 100);

    // abort on the third transfer of a ten-sample run
    start_run(10, 0, 0);
    sample_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("abort_run_valid", v16, 1);
      chk("abort_run_addr", a16, i);
      if (i == 2) abort = 1'b1;
      @(negedge clk);
    end
    abort = 1'b0;
    chk("after_abort_valid", v16, 0);
    chk("after_abort_busy", b16, 0);
    chk("after_abort_done", d16, 0);
    repeat (3) @(negedge clk);
    chk("after_abort_no_more", v16, 0);
    sample_ready = 1'b0;

    // reset in the middle of a run
    start_run(5, 5, 5);
    sample_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_valid", v16, 0);
    chk("midrst_addr", a16, 0);
    chk("midrst_busy", b16, 0);
    chk("midrst_done", d16, 0);
    chk("midrst_last", l16, 0);
    repeat (2) @(negedge clk);
    chk("midrst_stays_idle", v16, 0);
    sample_ready = 1'b0;

    for (int t = 0; t < 10; t++) begin
      start_run($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6));
      run(1, 400);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
